// File: rtl/sand_input_pkg.sv
// Shared types and constants for the PS/2 mouse sand-brush input path.
// Frame FSM states, decoded mouse packet layout and cursor home position.
package sand_input_pkg;

  localparam int DEF_COLUMNS    = 640;
  localparam int DEF_ROWS       = 480;
  localparam int CURSOR_RESET_X = DEF_COLUMNS / 2;
  localparam int CURSOR_RESET_Y = DEF_ROWS / 2;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  typedef struct packed {
    logic       left;
    logic       x_sign;
    logic       y_sign;
    logic       x_ovf;
    logic       y_ovf;
    logic [8:0] dx;
    logic [8:0] dy;
  } mouse_pkt_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver: synchronizers, clock glitch filter, 11-bit frame FSM, inactivity timeout.
// byte_valid_o/frame_err_o are one-cycle pulses a few cycles after the stop-bit clock edge; no backpressure.
module ps2_rx
  import sand_input_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]   clk_sync_q, dat_sync_q;
  logic         filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic         strobe;
  logic         clk_s, dat_s;

  frame_state_t state_q, state_d;
  logic [2:0]   bitcnt_q, bitcnt_d;
  logic [7:0]   shift_q, shift_d;
  logic         par_q, par_d;
  logic [TW-1:0] tocnt_q, tocnt_d;
  logic         vld_q, vld_d;
  logic         err_q, err_d;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Idle bus level is high, so the filter starts high and never sees a spurious fall out of reset.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  assign strobe = filt_q & ~filt_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    tocnt_d  = (state_q == IDLE || strobe) ? '0 : tocnt_q + TW'(1);

    if (state_q != IDLE && !strobe && tocnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tocnt_d = '0;
    end else if (strobe) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shift_d  = {dat_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          if (dat_s && (^{shift_q, par_q})) vld_d = 1'b1;
          else                              err_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tocnt_q    <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tocnt_q    <= tocnt_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = vld_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/sand_brush_input.sv
// PS/2 mouse to cursor tracker that issues single-pixel sand writes while the left button is held.
// Cursor/request update one cycle after the third packet byte; one write outstanding, extra draws are dropped.
module sand_brush_input
  import sand_input_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = DEF_COLUMNS,
  parameter int ACTIVE_ROWS    = DEF_ROWS,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 1,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              ps2_clk_i,
  input  logic                              ps2_data_i,
  output logic [$clog2(ACTIVE_COLUMNS)-1:0] cursor_x_o,
  output logic [$clog2(ACTIVE_ROWS)-1:0]    cursor_y_o,
  output logic                              left_btn_o,
  output logic                              draw_req_o,
  input  logic                              draw_ack_i,
  output logic [ADDR_WIDTH-1:0]             draw_address_o,
  output logic [DATA_WIDTH-1:0]             draw_data_o,
  output logic                              frame_err_o,
  output logic                              draw_drop_o
);

  localparam int XW = $clog2(ACTIVE_COLUMNS);
  localparam int YW = $clog2(ACTIVE_ROWS);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_err;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_vld),
    .frame_err_o  (rx_err)
  );

  logic [1:0]  idx_q, idx_d;
  logic [4:0]  hdr_q, hdr_d;   // {y_ovf, x_ovf, y_sign, x_sign, left}
  logic [7:0]  b1_q, b1_d;
  logic        pkt_done;
  mouse_pkt_t  pkt;

  always_comb begin
    idx_d    = idx_q;
    hdr_d    = hdr_q;
    b1_d     = b1_q;
    pkt_done = 1'b0;
    if (rx_err) begin
      idx_d = 2'd0;
    end else if (rx_vld) begin
      unique case (idx_q)
        2'd0: begin
          if (rx_byte[3]) begin
            hdr_d = {rx_byte[7:4], rx_byte[0]};
            idx_d = 2'd1;
          end
        end
        2'd1: begin
          b1_d  = rx_byte;
          idx_d = 2'd2;
        end
        default: begin
          pkt_done = 1'b1;
          idx_d    = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    pkt        = '0;
    pkt.left   = hdr_q[0];
    pkt.x_sign = hdr_q[1];
    pkt.y_sign = hdr_q[2];
    pkt.x_ovf  = hdr_q[3];
    pkt.y_ovf  = hdr_q[4];
    pkt.dx     = pkt.x_ovf ? 9'd0 : {pkt.x_sign, b1_q};
    pkt.dy     = pkt.y_ovf ? 9'd0 : {pkt.y_sign, rx_byte};
  end

  logic [XW-1:0]         x_q, x_d, x_new;
  logic [YW-1:0]         y_q, y_d, y_new;
  logic signed [11:0]    x_sum, y_sum;
  logic                  left_q, left_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_new;
  logic                  drop_q, drop_d;

  // Screen Y grows downward while PS/2 +Y means up, hence the subtraction.
  always_comb begin
    x_sum = $signed(12'(x_q)) + 12'($signed(pkt.dx));
    y_sum = $signed(12'(y_q)) - 12'($signed(pkt.dy));

    if (x_sum < 12'sd0)                                 x_new = '0;
    else if (x_sum > $signed(12'(ACTIVE_COLUMNS - 1)))  x_new = XW'(ACTIVE_COLUMNS - 1);
    else                                                x_new = XW'(x_sum);

    if (y_sum < 12'sd0)                                 y_new = '0;
    else if (y_sum > $signed(12'(ACTIVE_ROWS - 1)))     y_new = YW'(ACTIVE_ROWS - 1);
    else                                                y_new = YW'(y_sum);

    addr_new = ADDR_WIDTH'(y_new) * ADDR_WIDTH'(ACTIVE_COLUMNS) + ADDR_WIDTH'(x_new);
  end

  // A request still showing req_q, even on its ack cycle, counts as pending for a new draw.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    left_d = left_q;
    req_d  = req_q;
    addr_d = addr_q;
    drop_d = 1'b0;
    if (req_q && draw_ack_i) req_d = 1'b0;
    if (pkt_done) begin
      x_d    = x_new;
      y_d    = y_new;
      left_d = pkt.left;
      if (pkt.left) begin
        if (req_q) begin
          drop_d = 1'b1;
        end else begin
          req_d  = 1'b1;
          addr_d = addr_new;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      idx_q  <= 2'd0;
      hdr_q  <= '0;
      b1_q   <= '0;
      x_q    <= XW'(CURSOR_RESET_X);
      y_q    <= YW'(CURSOR_RESET_Y);
      left_q <= 1'b0;
      req_q  <= 1'b0;
      addr_q <= '0;
      drop_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      hdr_q  <= hdr_d;
      b1_q   <= b1_d;
      x_q    <= x_d;
      y_q    <= y_d;
      left_q <= left_d;
      req_q  <= req_d;
      addr_q <= addr_d;
      drop_q <= drop_d;
    end
  end

  assign cursor_x_o     = x_q;
  assign cursor_y_o     = y_q;
  assign left_btn_o     = left_q;
  assign draw_req_o     = req_q;
  assign draw_address_o = addr_q;
  assign draw_data_o    = '1;
  assign frame_err_o    = rx_err;
  assign draw_drop_o    = drop_q;

endmodule

// File: tb/tb_sand_brush_input.sv
// Bench for sand_brush_input: PS/2 byte-level driver, packet/cursor reference model, per-cycle compare.
// Timeout shortened so the whole run stays short.
module tb_sand_brush_input;

  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int AW   = 19;
  localparam int DW   = 1;
  localparam int FLEN = 8;
  localparam int TO   = 3000;
  localparam int HALF = 12;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic ack = 1'b0;
  logic [9:0]    cx;
  logic [8:0]    cy;
  logic          left;
  logic          req;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          ferr;
  logic          drop;

  always #5 clk = ~clk;

  sand_brush_input #(
    .ACTIVE_COLUMNS (COLS),
    .ACTIVE_ROWS    (ROWS),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .ps2_clk_i      (ps2_clk),
    .ps2_data_i     (ps2_data),
    .cursor_x_o     (cx),
    .cursor_y_o     (cy),
    .left_btn_o     (left),
    .draw_req_o     (req),
    .draw_ack_i     (ack),
    .draw_address_o (addr),
    .draw_data_o    (data),
    .frame_err_o    (ferr),
    .draw_drop_o    (drop)
  );

  int checks = 0;
  int errors = 0;

  int mx, my, mleft, mreq, maddr, midx;
  logic [7:0] mb0, mb1;
  int exp_err = 0, exp_drop = 0, seen_err = 0, seen_drop = 0;
  bit busy = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    mx = COLS / 2; my = ROWS / 2; mleft = 0; mreq = 0; maddr = 0; midx = 0;
  endtask

  // Byte-level reference of the packet rules: resync on header bit3, overflow zeroes an axis, clamping.
  task automatic model_byte(input logic [7:0] b, input bit good);
    int dx, dy;
    if (!good) begin
      exp_err++;
      midx = 0;
      return;
    end
    case (midx)
      0: if (b[3]) begin mb0 = b; midx = 1; end
      1: begin mb1 = b; midx = 2; end
      default: begin
        dx = mb0[6] ? 0 : (mb0[4] ? int'(mb1) - 256 : int'(mb1));
        dy = mb0[7] ? 0 : (mb0[5] ? int'(b) - 256 : int'(b));
        mx = clamp(mx + dx, 0, COLS - 1);
        my = clamp(my - dy, 0, ROWS - 1);
        mleft = int'(mb0[0]);
        if (mleft != 0) begin
          if (mreq != 0) exp_drop++;
          else begin mreq = 1; maddr = my * COLS + mx; end
        end
        midx = 0;
      end
    endcase
  endtask

  task automatic check_all();
    chk("cursor_x", int'(cx), mx);
    chk("cursor_y", int'(cy), my);
    chk("left_btn", int'(left), mleft);
    chk("draw_req", int'(req), mreq);
    chk("draw_address", int'(addr), maddr);
    chk("draw_data", int'(data), 1);
  endtask

  always @(negedge clk) begin
    if (ferr) seen_err++;
    if (drop) seen_drop++;
    if (!busy) check_all();
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    busy = 1'b1;
    for (int i = 0; i < 11; i++) drive_bit(f[i]);
    repeat (30) @(negedge clk);
    @(posedge clk);
    model_byte(b, !bad_par);
    busy = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic send_partial(input int n);
    busy = 1'b1;
    for (int i = 0; i < n; i++) drive_bit((i == 0) ? 1'b0 : 1'($urandom_range(1)));
    ps2_data = 1'b1;
  endtask

  task automatic ack_req();
    if (mreq != 0) begin
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      mreq = 0;
    end
  endtask

  task automatic ack_noise();
    if (mreq == 0) begin
      @(negedge clk);
      ack = 1'b1;
      repeat (3) @(negedge clk);
      ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    busy = 1'b1;
    #2;
    reset_i = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    busy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    bit got;
    int base;
    logic [7:0] r0, r1, r2;

    model_reset();
    repeat (4) @(negedge clk);
    #1;
    check_all();
    chk("rst_x_lit", int'(cx), 320);
    chk("rst_y_lit", int'(cy), 240);
    chk("rst_err", int'(ferr), 0);
    chk("rst_drop", int'(drop), 0);
    reset_i = 1'b1;
    busy = 1'b0;
    repeat (5) @(negedge clk);

    // Basic left-held move and request handshake
    send_pkt(8'h09, 8'h0A, 8'h05);
    chk("pkt1_x_lit", int'(cx), 330);
    chk("pkt1_y_lit", int'(cy), 235);
    chk("pkt1_req_lit", int'(req), 1);
    chk("pkt1_addr_lit", int'(addr), 150730);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("addr_hold", int'(addr), 150730);
      chk("req_hold", int'(req), 1);
    end
    ack_req();
    @(negedge clk);
    #1;
    chk("req_after_ack", int'(req), 0);

    // Clamping at both X edges, no draws
    do_reset();
    repeat (4) send_pkt(8'h18, 8'h9C, 8'h00);
    chk("clamp_lo_lit", int'(cx), 0);
    chk("clamp_lo_req", int'(req), 0);
    repeat (6) send_pkt(8'h08, 8'h7F, 8'h00);
    chk("clamp_hi_lit", int'(cx), 639);
    chk("clamp_hi_req", int'(req), 0);

    // Parity error then recovery
    send_byte(8'h08, 1'b1);
    chk("parity_err_lit", seen_err, 1);
    chk("parity_err_cnt", seen_err, exp_err);
    chk("parity_x", int'(cx), 639);
    send_pkt(8'h18, 8'hF6, 8'h00);
    chk("after_parity_x_lit", int'(cx), 629);

    // Mid-frame inactivity timeout then recovery
    send_partial(4);
    repeat (TO / 2) @(negedge clk);
    chk("no_early_timeout", seen_err, exp_err);
    base = seen_err;
    got = 1'b0;
    for (int i = 0; i < TO + 200 && !got; i++) begin
      @(negedge clk);
      #1;
      if (seen_err != base) got = 1'b1;
    end
    chk("timeout_seen", int'(got), 1);
    exp_err++;
    midx = 0;
    repeat (20) @(negedge clk);
    chk("timeout_err_cnt", seen_err, exp_err);
    busy = 1'b0;
    send_pkt(8'h08, 8'h01, 8'h01);
    chk("after_to_x_lit", int'(cx), 630);
    chk("after_to_y_lit", int'(cy), 239);

    // Drop while a request is pending, then asynchronous reset mid-frame
    send_pkt(8'h09, 8'h01, 8'h00);
    chk("drop_first_addr_lit", int'(addr), 153591);
    send_pkt(8'h09, 8'h02, 8'h00);
    chk("drop_x_lit", int'(cx), 633);
    chk("drop_addr_lit", int'(addr), 153591);
    chk("drop_cnt_lit", seen_drop, 1);
    chk("drop_cnt", seen_drop, exp_drop);
    send_partial(3);
    @(negedge clk);
    #2;
    reset_i = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("midframe_rst_x_lit", int'(cx), 320);
    chk("midframe_rst_req_lit", int'(req), 0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    busy = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    repeat (5) @(negedge clk);
    send_pkt(8'h28, 8'h03, 8'hFE);
    chk("post_rst_x_lit", int'(cx), 323);
    chk("post_rst_y_lit", int'(cy), 242);

    // Randomized packets with occasional header resync, bad parity and ack traffic
    for (int p = 0; p < 20; p++) begin
      r0 = 8'($urandom);
      if ($urandom_range(9) != 0) r0[3] = 1'b1;
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      send_byte(r0, $urandom_range(15) == 0);
      send_byte(r1, $urandom_range(15) == 0);
      send_byte(r2, $urandom_range(15) == 0);
      case ($urandom_range(3))
        0: ack_req();
        1: ack_noise();
        default: ;
      endcase
    end
    ack_req();
    repeat (5) @(negedge clk);
    #1;
    chk("final_err_cnt", seen_err, exp_err);
    chk("final_drop_cnt", seen_drop, exp_drop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
